// File: rtl/wja_axil_pkg.sv
// Shared types and constants for the wja_axil command-driven AXI4-Lite master.
// Holds the FSM state encoding, the response codes and the default bus widths.
package wja_axil_pkg;

    localparam int DEF_ADDR_W = 5;
    localparam int DEF_DATA_W = 32;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WADDR,
        ST_WRESP,
        ST_RADDR,
        ST_RDATA,
        ST_RSP
    } state_e;

    // States in which the master waits on the AXI slave; only these advance the timeout.
    function automatic logic bus_phase(input state_e s);
        return (s == ST_WADDR) || (s == ST_WRESP) || (s == ST_RADDR) || (s == ST_RDATA);
    endfunction

endpackage

// File: rtl/wja_axil_master_if.sv
// Command/response port plus the AXI4-Lite master port, bundled for wja_axil_master.
// The master modport is the block's own view; slave is the view of whatever drives it.
interface wja_axil_master_if
    import wja_axil_pkg::*;
#(
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int DATA_W = DEF_DATA_W
);

    logic              cmd_valid;
    logic              cmd_ready;
    logic              cmd_write;
    logic [ADDR_W-1:0] cmd_addr;
    logic [DATA_W-1:0] cmd_wdata;
    logic [DATA_W/8-1:0] cmd_wstrb;

    logic              rsp_valid;
    logic              rsp_ready;
    logic [DATA_W-1:0] rsp_rdata;
    logic [1:0]        rsp_resp;
    logic              rsp_timeout;

    logic [ADDR_W-1:0] m_axi_awaddr;
    logic [2:0]        m_axi_awprot;
    logic              m_axi_awvalid;
    logic              m_axi_awready;
    logic [DATA_W-1:0] m_axi_wdata;
    logic [DATA_W/8-1:0] m_axi_wstrb;
    logic              m_axi_wvalid;
    logic              m_axi_wready;
    logic [1:0]        m_axi_bresp;
    logic              m_axi_bvalid;
    logic              m_axi_bready;
    logic [ADDR_W-1:0] m_axi_araddr;
    logic [2:0]        m_axi_arprot;
    logic              m_axi_arvalid;
    logic              m_axi_arready;
    logic [DATA_W-1:0] m_axi_rdata;
    logic [1:0]        m_axi_rresp;
    logic              m_axi_rvalid;
    logic              m_axi_rready;

    modport master (
        input  cmd_valid, cmd_write, cmd_addr, cmd_wdata, cmd_wstrb, rsp_ready,
        input  m_axi_awready, m_axi_wready, m_axi_bresp, m_axi_bvalid,
        input  m_axi_arready, m_axi_rdata, m_axi_rresp, m_axi_rvalid,
        output cmd_ready, rsp_valid, rsp_rdata, rsp_resp, rsp_timeout,
        output m_axi_awaddr, m_axi_awprot, m_axi_awvalid, m_axi_wdata, m_axi_wstrb, m_axi_wvalid,
        output m_axi_bready, m_axi_araddr, m_axi_arprot, m_axi_arvalid, m_axi_rready
    );

    modport slave (
        output cmd_valid, cmd_write, cmd_addr, cmd_wdata, cmd_wstrb, rsp_ready,
        output m_axi_awready, m_axi_wready, m_axi_bresp, m_axi_bvalid,
        output m_axi_arready, m_axi_rdata, m_axi_rresp, m_axi_rvalid,
        input  cmd_ready, rsp_valid, rsp_rdata, rsp_resp, rsp_timeout,
        input  m_axi_awaddr, m_axi_awprot, m_axi_awvalid, m_axi_wdata, m_axi_wstrb, m_axi_wvalid,
        input  m_axi_bready, m_axi_araddr, m_axi_arprot, m_axi_arvalid, m_axi_rready
    );

endinterface

// File: rtl/wja_axil_timeout.sv
// Saturating cycle counter that flags a stalled AXI transaction.
// With TIMEOUT=0 the counter is not built and expired_o stays low.
module wja_axil_timeout #(
    parameter int TIMEOUT = 255
) (
    input  logic clk,
    input  logic reset,
    input  logic clear_i,
    input  logic en_i,
    output logic expired_o
);

    generate
        if (TIMEOUT > 0) begin : g_timer
            localparam int CNT_W = $clog2(TIMEOUT + 1);
            localparam logic [CNT_W-1:0] LIMIT = CNT_W'(TIMEOUT);

            logic [CNT_W-1:0] cnt_q;

            always_ff @(posedge clk) begin
                if (reset || clear_i) begin
                    cnt_q <= '0;
                end else if (en_i && (cnt_q != LIMIT)) begin
                    cnt_q <= cnt_q + 1'b1;
                end
            end

            assign expired_o = (cnt_q == LIMIT);
        end else begin : g_off
            assign expired_o = 1'b0;
        end
    endgenerate

endmodule

// File: rtl/wja_axil_master.sv
// Single-outstanding AXI4-Lite master: one command in, one AXI transaction, one response out.
// Every output is a register except cmd_ready, which is decoded from the state.
module wja_axil_master
    import wja_axil_pkg::*;
#(
    parameter int ADDR_W  = DEF_ADDR_W,
    parameter int DATA_W  = DEF_DATA_W,
    parameter int TIMEOUT = 255
) (
    input  logic              clk,
    input  logic              reset,
    wja_axil_master_if.master bus
);

    localparam int STRB_W = DATA_W / 8;

    state_e              state_q;
    logic [ADDR_W-1:0]   addr_q;
    logic [DATA_W-1:0]   wdata_q;
    logic [STRB_W-1:0]   wstrb_q;
    logic                awvalid_q;
    logic                wvalid_q;
    logic                bready_q;
    logic                arvalid_q;
    logic                rready_q;
    logic                rsp_valid_q;
    logic [DATA_W-1:0]   rsp_rdata_q;
    logic [1:0]          rsp_resp_q;
    logic                rsp_timeout_q;

    logic accept;
    logic busy;
    logic expired;
    logic resp_hs;
    logic abort;
    logic aw_fin;
    logic w_fin;

    assign bus.cmd_ready = (state_q == ST_IDLE) && !reset;
    assign accept        = bus.cmd_ready && bus.cmd_valid;
    assign busy          = bus_phase(state_q);

    // A response arriving on the expiry cycle still wins; the slave considers it delivered.
    assign resp_hs = ((state_q == ST_WRESP) && bus.m_axi_bvalid) ||
                     ((state_q == ST_RDATA) && bus.m_axi_rvalid);
    assign abort   = busy && expired && !resp_hs;

    // A channel counts as finished once its valid has dropped or handshakes this cycle.
    assign aw_fin = !awvalid_q || bus.m_axi_awready;
    assign w_fin  = !wvalid_q  || bus.m_axi_wready;

    wja_axil_timeout #(
        .TIMEOUT (TIMEOUT)
    ) u_timeout (
        .clk       (clk),
        .reset     (reset),
        .clear_i   (accept),
        .en_i      (busy),
        .expired_o (expired)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= ST_IDLE;
            addr_q        <= '0;
            wdata_q       <= '0;
            wstrb_q       <= '0;
            awvalid_q     <= 1'b0;
            wvalid_q      <= 1'b0;
            bready_q      <= 1'b0;
            arvalid_q     <= 1'b0;
            rready_q      <= 1'b0;
            rsp_valid_q   <= 1'b0;
            rsp_rdata_q   <= '0;
            rsp_resp_q    <= RESP_OKAY;
            rsp_timeout_q <= 1'b0;
        end else if (abort) begin
            awvalid_q     <= 1'b0;
            wvalid_q      <= 1'b0;
            bready_q      <= 1'b0;
            arvalid_q     <= 1'b0;
            rready_q      <= 1'b0;
            rsp_valid_q   <= 1'b1;
            rsp_rdata_q   <= '0;
            rsp_resp_q    <= RESP_SLVERR;
            rsp_timeout_q <= 1'b1;
            state_q       <= ST_RSP;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (bus.cmd_valid) begin
                        addr_q  <= bus.cmd_addr;
                        wdata_q <= bus.cmd_wdata;
                        wstrb_q <= bus.cmd_wstrb;
                        if (bus.cmd_write) begin
                            awvalid_q <= 1'b1;
                            wvalid_q  <= 1'b1;
                            state_q   <= ST_WADDR;
                        end else begin
                            arvalid_q <= 1'b1;
                            state_q   <= ST_RADDR;
                        end
                    end
                end
                ST_WADDR: begin
                    if (bus.m_axi_awready) awvalid_q <= 1'b0;
                    if (bus.m_axi_wready)  wvalid_q  <= 1'b0;
                    if (aw_fin && w_fin) begin
                        bready_q <= 1'b1;
                        state_q  <= ST_WRESP;
                    end
                end
                ST_WRESP: begin
                    if (bus.m_axi_bvalid) begin
                        bready_q      <= 1'b0;
                        rsp_valid_q   <= 1'b1;
                        rsp_rdata_q   <= '0;
                        rsp_resp_q    <= bus.m_axi_bresp;
                        rsp_timeout_q <= 1'b0;
                        state_q       <= ST_RSP;
                    end
                end
                ST_RADDR: begin
                    if (bus.m_axi_arready) begin
                        arvalid_q <= 1'b0;
                        rready_q  <= 1'b1;
                        state_q   <= ST_RDATA;
                    end
                end
                ST_RDATA: begin
                    if (bus.m_axi_rvalid) begin
                        rready_q      <= 1'b0;
                        rsp_valid_q   <= 1'b1;
                        rsp_rdata_q   <= bus.m_axi_rdata;
                        rsp_resp_q    <= bus.m_axi_rresp;
                        rsp_timeout_q <= 1'b0;
                        state_q       <= ST_RSP;
                    end
                end
                ST_RSP: begin
                    if (bus.rsp_ready) begin
                        rsp_valid_q <= 1'b0;
                        state_q     <= ST_IDLE;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign bus.m_axi_awaddr  = addr_q;
    assign bus.m_axi_awprot  = 3'b000;
    assign bus.m_axi_awvalid = awvalid_q;
    assign bus.m_axi_wdata   = wdata_q;
    assign bus.m_axi_wstrb   = wstrb_q;
    assign bus.m_axi_wvalid  = wvalid_q;
    assign bus.m_axi_bready  = bready_q;
    assign bus.m_axi_araddr  = addr_q;
    assign bus.m_axi_arprot  = 3'b000;
    assign bus.m_axi_arvalid = arvalid_q;
    assign bus.m_axi_rready  = rready_q;
    assign bus.rsp_valid     = rsp_valid_q;
    assign bus.rsp_rdata     = rsp_rdata_q;
    assign bus.rsp_resp      = rsp_resp_q;
    assign bus.rsp_timeout   = rsp_timeout_q;

endmodule

// File: tb/tb_wja_axil_master.sv
// Bench for wja_axil_master against a small behavioural AXI4-Lite register slave.
// Slave modes: 0 zero-wait, 1 W ready 3 cycles before AW, 2 never ready, 3 holds back B.
module tb_wja_axil_master;
    import wja_axil_pkg::*;

    localparam int ADDR_W  = 5;
    localparam int DATA_W  = 32;
    localparam int TIMEOUT = 8;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    wja_axil_master_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

    wja_axil_master #(
        .ADDR_W  (ADDR_W),
        .DATA_W  (DATA_W),
        .TIMEOUT (TIMEOUT)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    // ---------------- behavioural slave ----------------
    logic [1:0]  mode = 2'd0;
    logic [31:0] mem [8];
    int          skew_cnt;
    int          cyc = 0;
    logic        got_aw, got_w;
    logic [4:0]  aw_addr_l;
    logic [31:0] w_data_l;
    logic [3:0]  w_strb_l;
    logic        bvalid_q, rvalid_q;
    logic [1:0]  bresp_q, rresp_q;
    logic [31:0] rdata_q;
    logic        aw_hs, w_hs, ar_hs;
    logic [4:0]  wr_addr;
    logic [31:0] wr_data;
    logic [3:0]  wr_strb;

    assign bus.m_axi_awready = (mode == 2'd0 || mode == 2'd3) ? 1'b1 : (mode == 2'd1) ? (skew_cnt == 4) : 1'b0;
    assign bus.m_axi_wready  = (mode == 2'd0 || mode == 2'd3) ? 1'b1 : (mode == 2'd1) ? (skew_cnt == 1) : 1'b0;
    assign bus.m_axi_arready = (mode != 2'd2);
    assign bus.m_axi_bvalid  = bvalid_q;
    assign bus.m_axi_bresp   = bresp_q;
    assign bus.m_axi_rvalid  = rvalid_q;
    assign bus.m_axi_rdata   = rdata_q;
    assign bus.m_axi_rresp   = rresp_q;

    assign aw_hs   = bus.m_axi_awvalid && bus.m_axi_awready;
    assign w_hs    = bus.m_axi_wvalid && bus.m_axi_wready;
    assign ar_hs   = bus.m_axi_arvalid && bus.m_axi_arready;
    assign wr_addr = aw_hs ? bus.m_axi_awaddr : aw_addr_l;
    assign wr_data = w_hs ? bus.m_axi_wdata : w_data_l;
    assign wr_strb = w_hs ? bus.m_axi_wstrb : w_strb_l;

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] data, input logic [3:0] strb);
        logic [31:0] m;
        m = old;
        for (int b = 0; b < 4; b++) if (strb[b]) m[8*b +: 8] = data[8*b +: 8];
        return m;
    endfunction

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (reset) begin
            skew_cnt  <= 0;
            got_aw    <= 1'b0;
            got_w     <= 1'b0;
            aw_addr_l <= '0;
            w_data_l  <= '0;
            w_strb_l  <= '0;
            bvalid_q  <= 1'b0;
            bresp_q   <= 2'b00;
            rvalid_q  <= 1'b0;
            rresp_q   <= 2'b00;
            rdata_q   <= '0;
        end else begin
            skew_cnt <= (bus.m_axi_awvalid || bus.m_axi_wvalid) ? skew_cnt + 1 : 0;
            if (bvalid_q && bus.m_axi_bready) bvalid_q <= 1'b0;
            if (rvalid_q && bus.m_axi_rready) rvalid_q <= 1'b0;
            if (aw_hs) begin got_aw <= 1'b1; aw_addr_l <= bus.m_axi_awaddr; end
            if (w_hs) begin got_w <= 1'b1; w_data_l <= bus.m_axi_wdata; w_strb_l <= bus.m_axi_wstrb; end
            if ((got_aw || aw_hs) && (got_w || w_hs)) begin
                mem[wr_addr[4:2]] <= merge(mem[wr_addr[4:2]], wr_data, wr_strb);
                got_aw  <= 1'b0;
                got_w   <= 1'b0;
                bresp_q <= (wr_addr[4:2] == 3'd7) ? RESP_SLVERR : RESP_OKAY;
                if (mode != 2'd3) bvalid_q <= 1'b1;
            end
            if (ar_hs) begin
                rvalid_q <= 1'b1;
                rdata_q  <= mem[bus.m_axi_araddr[4:2]];
                rresp_q  <= (bus.m_axi_araddr[4:2] == 3'd7) ? RESP_SLVERR : RESP_OKAY;
            end
        end
    end

    // ---------------- command driver ----------------
    int          n_pass = 0;
    int          n_total = 0;
    int          lat, aw_only, w_only, b_hs, ar_cycles, first_valid, acc_cyc;
    int          bp_bad, bp_rdy_bad;
    logic [31:0] r_rdata;
    logic [1:0]  r_resp;
    logic        r_tmo;
    logic [4:0]  r_axi;
    logic        post_rsp_valid, post_cmd_ready;

    task automatic do_cmd(input logic wr, input logic [4:0] addr, input logic [31:0] wdata,
                          input logic [3:0] strb, input int hold);
        int c;
        bus.rsp_ready = (hold == 0);
        c = 0;
        while (bus.cmd_ready !== 1'b1 && c < 20) begin @(posedge clk); #1; c++; end
        if (bus.cmd_ready !== 1'b1) begin
            n_total++;
            $display("FAIL cmd_ready_wait: cmd_ready=%b after %0d cycles, required 1", bus.cmd_ready, c);
        end
        bus.cmd_valid = 1'b1;
        bus.cmd_write = wr;
        bus.cmd_addr  = addr;
        bus.cmd_wdata = wdata;
        bus.cmd_wstrb = strb;
        @(posedge clk); #1;
        acc_cyc = cyc;
        bus.cmd_valid = 1'b0;
        lat = 1; aw_only = 0; w_only = 0; b_hs = 0; ar_cycles = 0; first_valid = 0;
        while (bus.rsp_valid !== 1'b1 && lat < 50) begin
            if (first_valid == 0 && (bus.m_axi_awvalid || bus.m_axi_wvalid || bus.m_axi_arvalid)) first_valid = lat;
            if (bus.m_axi_awvalid && !bus.m_axi_wvalid) aw_only++;
            if (bus.m_axi_wvalid && !bus.m_axi_awvalid) w_only++;
            if (bus.m_axi_bvalid && bus.m_axi_bready) b_hs++;
            if (bus.m_axi_arvalid) ar_cycles++;
            @(posedge clk); #1;
            lat++;
        end
        if (bus.rsp_valid !== 1'b1) begin
            n_total++;
            $display("FAIL rsp_wait: rsp_valid=%b after %0d cycles, required 1", bus.rsp_valid, lat);
        end
        r_rdata = bus.rsp_rdata;
        r_resp  = bus.rsp_resp;
        r_tmo   = bus.rsp_timeout;
        r_axi   = {bus.m_axi_awvalid, bus.m_axi_wvalid, bus.m_axi_bready, bus.m_axi_arvalid, bus.m_axi_rready};
        bp_bad = 0; bp_rdy_bad = 0;
        for (int i = 0; i < hold; i++) begin
            @(posedge clk); #1;
            if (bus.rsp_valid !== 1'b1 || bus.rsp_rdata !== r_rdata || bus.rsp_resp !== r_resp || bus.rsp_timeout !== r_tmo) bp_bad++;
            if (bus.cmd_ready !== 1'b0) bp_rdy_bad++;
        end
        bus.rsp_ready = 1'b1;
        @(posedge clk); #1;
        post_rsp_valid = bus.rsp_valid;
        post_cmd_ready = bus.cmd_ready;
        $display("txn %s addr=0x%02h wdata=0x%08h strb=%b -> rdata=0x%08h resp=%b tmo=%b lat=%0d",
                 wr ? "WR" : "RD", addr, wdata, strb, r_rdata, r_resp, r_tmo, lat);
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        logic [9:0]   ctl;
        logic [104:0] dat;
        repeat (3) @(posedge clk);
        #1;
        ctl = {bus.cmd_ready, bus.m_axi_awvalid, bus.m_axi_wvalid, bus.m_axi_bready, bus.m_axi_arvalid,
               bus.m_axi_rready, bus.rsp_valid, bus.rsp_timeout, bus.rsp_resp[1], bus.rsp_resp[0]};
        dat = {bus.m_axi_awaddr, bus.m_axi_wdata, bus.m_axi_wstrb, bus.m_axi_araddr, bus.rsp_rdata,
               bus.m_axi_awprot, bus.m_axi_arprot, 1'b0};
        n_total++; if (ctl !== '0) $display("FAIL reset_ctl: got %b required 0", ctl); else n_pass++;
        n_total++; if (dat !== '0) $display("FAIL reset_data: got %h required 0", dat); else n_pass++;
        reset = 1'b0;
        @(posedge clk); #1;
        n_total++; if (bus.cmd_ready !== 1'b1) $display("FAIL reset_release_cmd_ready: got %b required 1", bus.cmd_ready); else n_pass++;
    endtask

    task automatic test_write();
        do_cmd(1'b1, 5'h00, 32'hDEADBEEF, 4'hF, 0);
        n_total++; if (first_valid !== 1) $display("FAIL write_awvalid_cycle: got %0d required 1", first_valid); else n_pass++;
        n_total++; if (lat !== 3) $display("FAIL write_latency: got %0d required 3", lat); else n_pass++;
        n_total++; if (r_resp !== RESP_OKAY) $display("FAIL write_resp: got %b required 00", r_resp); else n_pass++;
        n_total++; if (r_rdata !== 32'h0 || r_tmo !== 1'b0) $display("FAIL write_rdata_tmo: got %h/%b required 0/0", r_rdata, r_tmo); else n_pass++;
        n_total++; if (b_hs !== 1) $display("FAIL write_b_handshakes: got %0d required 1", b_hs); else n_pass++;
        n_total++; if (mem[0] !== 32'hDEADBEEF) $display("FAIL write_reg0: got %h required deadbeef", mem[0]); else n_pass++;
    endtask

    task automatic test_readback();
        do_cmd(1'b0, 5'h00, 32'h0, 4'h0, 0);
        n_total++; if (r_rdata !== 32'hDEADBEEF) $display("FAIL read_rdata: got %h required deadbeef", r_rdata); else n_pass++;
        n_total++; if (r_resp !== RESP_OKAY) $display("FAIL read_resp: got %b required 00", r_resp); else n_pass++;
        n_total++; if (lat !== 3) $display("FAIL read_latency: got %0d required 3", lat); else n_pass++;
    endtask

    task automatic test_wstrb_slverr();
        do_cmd(1'b1, 5'h04, 32'hFFFFFFFF, 4'hF, 0);
        do_cmd(1'b1, 5'h04, 32'h11223344, 4'b0101, 0);
        do_cmd(1'b0, 5'h04, 32'h0, 4'h0, 0);
        n_total++; if (r_rdata !== 32'hFF22FF44) $display("FAIL wstrb_merge: got %h required ff22ff44", r_rdata); else n_pass++;
        do_cmd(1'b1, 5'h1C, 32'h00000001, 4'hF, 0);
        n_total++; if (r_resp !== RESP_SLVERR || r_tmo !== 1'b0) $display("FAIL bresp_capture: got %b/%b required 10/0", r_resp, r_tmo); else n_pass++;
        do_cmd(1'b0, 5'h1C, 32'h0, 4'h0, 0);
        n_total++; if (r_resp !== RESP_SLVERR || r_rdata !== 32'h1) $display("FAIL rresp_capture: got %b/%h required 10/00000001", r_resp, r_rdata); else n_pass++;
    endtask

    task automatic test_skew();
        mode = 2'd1;
        do_cmd(1'b1, 5'h08, 32'hCAFEF00D, 4'hF, 0);
        n_total++; if (lat !== 7) $display("FAIL skew_latency: got %0d required 7", lat); else n_pass++;
        n_total++; if (aw_only !== 3) $display("FAIL skew_aw_alone: got %0d cycles required 3", aw_only); else n_pass++;
        n_total++; if (w_only !== 0) $display("FAIL skew_w_alone: got %0d cycles required 0", w_only); else n_pass++;
        n_total++; if (b_hs !== 1) $display("FAIL skew_b_handshakes: got %0d required 1", b_hs); else n_pass++;
        n_total++; if (r_resp !== RESP_OKAY || r_tmo !== 1'b0) $display("FAIL skew_resp: got %b/%b required 00/0", r_resp, r_tmo); else n_pass++;
        mode = 2'd0;
        do_cmd(1'b0, 5'h08, 32'h0, 4'h0, 0);
        n_total++; if (r_rdata !== 32'hCAFEF00D) $display("FAIL skew_readback: got %h required cafef00d", r_rdata); else n_pass++;
    endtask

    task automatic test_timeout();
        mode = 2'd2;
        do_cmd(1'b0, 5'h04, 32'h0, 4'h0, 0);
        n_total++; if (lat !== 10) $display("FAIL timeout_latency: got %0d required 10", lat); else n_pass++;
        n_total++; if (ar_cycles !== 9) $display("FAIL timeout_arvalid_cycles: got %0d required 9", ar_cycles); else n_pass++;
        n_total++; if (r_tmo !== 1'b1) $display("FAIL timeout_flag: got %b required 1", r_tmo); else n_pass++;
        n_total++; if (r_resp !== RESP_SLVERR) $display("FAIL timeout_resp: got %b required 10", r_resp); else n_pass++;
        n_total++; if (r_rdata !== 32'h0) $display("FAIL timeout_rdata: got %h required 0", r_rdata); else n_pass++;
        n_total++; if (r_axi !== 5'b0) $display("FAIL timeout_axi_dropped: got %b required 00000", r_axi); else n_pass++;
        mode = 2'd0;
        do_cmd(1'b0, 5'h00, 32'h0, 4'h0, 0);
        n_total++; if (r_rdata !== 32'hDEADBEEF || r_tmo !== 1'b0) $display("FAIL timeout_recovery: got %h/%b required deadbeef/0", r_rdata, r_tmo); else n_pass++;
    endtask

    task automatic test_backpressure();
        do_cmd(1'b0, 5'h00, 32'h0, 4'h0, 5);
        n_total++; if (bp_bad !== 0) $display("FAIL bp_payload_stable: got %0d unstable cycles required 0", bp_bad); else n_pass++;
        n_total++; if (bp_rdy_bad !== 0) $display("FAIL bp_cmd_ready_low: got %0d cycles high required 0", bp_rdy_bad); else n_pass++;
        n_total++; if (post_rsp_valid !== 1'b0) $display("FAIL bp_rsp_release: got rsp_valid=%b required 0", post_rsp_valid); else n_pass++;
        n_total++; if (r_rdata !== 32'hDEADBEEF) $display("FAIL bp_rdata: got %h required deadbeef", r_rdata); else n_pass++;
    endtask

    task automatic test_back_to_back();
        int a1;
        do_cmd(1'b1, 5'h14, 32'h0BADCAFE, 4'hF, 0);
        a1 = acc_cyc;
        n_total++; if (post_cmd_ready !== 1'b1) $display("FAIL b2b_cmd_ready: got %b required 1", post_cmd_ready); else n_pass++;
        do_cmd(1'b0, 5'h14, 32'h0, 4'h0, 0);
        n_total++; if (acc_cyc - a1 !== 4) $display("FAIL b2b_spacing: got %0d cycles required 4", acc_cyc - a1); else n_pass++;
        n_total++; if (r_rdata !== 32'h0BADCAFE) $display("FAIL b2b_rdata: got %h required 0badcafe", r_rdata); else n_pass++;
    endtask

    task automatic test_reset_mid();
        logic [9:0] ctl;
        mode = 2'd3;
        bus.cmd_valid = 1'b1;
        bus.cmd_write = 1'b1;
        bus.cmd_addr  = 5'h10;
        bus.cmd_wdata = 32'hA5A5A5A5;
        bus.cmd_wstrb = 4'hF;
        @(posedge clk); #1;
        bus.cmd_valid = 1'b0;
        repeat (2) begin @(posedge clk); #1; end
        n_total++; if (bus.m_axi_bready !== 1'b1) $display("FAIL rstmid_in_wresp: bready=%b required 1", bus.m_axi_bready); else n_pass++;
        reset = 1'b1;
        @(posedge clk); #1;
        ctl = {bus.cmd_ready, bus.m_axi_awvalid, bus.m_axi_wvalid, bus.m_axi_bready, bus.m_axi_arvalid,
               bus.m_axi_rready, bus.rsp_valid, bus.rsp_timeout, bus.rsp_resp[1], bus.rsp_resp[0]};
        n_total++; if (ctl !== '0 || bus.m_axi_awaddr !== '0 || bus.m_axi_wdata !== '0)
            $display("FAIL rstmid_outputs: ctl=%b awaddr=%h wdata=%h required all 0", ctl, bus.m_axi_awaddr, bus.m_axi_wdata);
        else n_pass++;
        reset = 1'b0;
        mode  = 2'd0;
        @(posedge clk); #1;
        n_total++; if (bus.cmd_ready !== 1'b1) $display("FAIL rstmid_cmd_ready: got %b required 1", bus.cmd_ready); else n_pass++;
        do_cmd(1'b1, 5'h0C, 32'h12345678, 4'hF, 0);
        n_total++; if (lat !== 3 || r_resp !== RESP_OKAY) $display("FAIL rstmid_write: lat=%0d resp=%b required 3/00", lat, r_resp); else n_pass++;
        n_total++; if (mem[3] !== 32'h12345678) $display("FAIL rstmid_mem: got %h required 12345678", mem[3]); else n_pass++;
    endtask

    initial begin
        bus.cmd_valid = 1'b0;
        bus.cmd_write = 1'b0;
        bus.cmd_addr  = '0;
        bus.cmd_wdata = '0;
        bus.cmd_wstrb = '0;
        bus.rsp_ready = 1'b1;
        test_reset();
        test_write();
        test_readback();
        test_wstrb_slverr();
        test_skew();
        test_timeout();
        test_backpressure();
        test_back_to_back();
        test_reset_mid();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, %0d/%0d checks passed so far", n_pass, n_total);
        $fatal(1, "watchdog expired");
    end

endmodule
